// File: rtl/score_keeper.sv
// Match scorekeeper: edge-detects the ball mover's score flags, keeps per-player points,
// gates the ball with a serve delay and declares a winner. Macro SCORE_KEEPER_DEUCE_EN enables win-by-two.
module score_keeper #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter logic [25:0] HOLD_CYCLES = 26'd50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       player_0_scores,
  input  logic       player_1_scores,
  output logic [3:0] score_0,
  output logic [3:0] score_1,
  output logic       go_ball,
  output logic       point,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [25:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]  score_0_q, score_0_d;
  logic [3:0]  score_1_q, score_1_d;
  logic        point_q, point_d;
  logic        winner_q, winner_d;
  logic        prev_0_q, prev_0_d;
  logic        prev_1_q, prev_1_d;

  logic       rise_0, rise_1;
  logic [3:0] inc_0, inc_1;

  function automatic logic win_rule(input logic [3:0] mine, input logic [3:0] other);
`ifdef SCORE_KEEPER_DEUCE_EN
    logic [4:0] lead;
    lead = {1'b0, mine} - {1'b0, other};
    return ((32'(mine) >= WIN_SCORE) && (lead >= 5'd2)) || (mine == 4'd15);
`else
    return (32'(mine) >= WIN_SCORE) && (other <= 4'd15);
`endif
  endfunction

  assign rise_0 = player_0_scores & ~prev_0_q;
  assign rise_1 = player_1_scores & ~prev_1_q;

  // Saturating increments: a score never wraps past 15.
  assign inc_0 = (score_0_q == 4'd15) ? 4'd15 : score_0_q + 4'd1;
  assign inc_1 = (score_1_q == 4'd15) ? 4'd15 : score_1_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    score_0_d  = score_0_q;
    score_1_d  = score_1_q;
    winner_d   = winner_q;
    point_d    = 1'b0;
    prev_0_d   = player_0_scores;
    prev_1_d   = player_1_scores;

    if (new_game) begin
      state_d    = ST_HOLD;
      hold_cnt_d = 26'd0;
      score_0_d  = 4'd0;
      score_1_d  = 4'd0;
      winner_d   = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_CYCLES - 26'd1) begin
            hold_cnt_d = 26'd0;
            state_d    = ST_PLAY;
          end else begin
            hold_cnt_d = hold_cnt_q + 26'd1;
          end
        end
        ST_PLAY: begin
          // A simultaneous rise is ambiguous and credits nobody.
          if (rise_0 && !rise_1) begin
            score_0_d = inc_0;
            point_d   = 1'b1;
            if (win_rule(inc_0, score_1_q)) begin
              state_d  = ST_OVER;
              winner_d = 1'b0;
            end else begin
              state_d = ST_HOLD;
            end
          end else if (rise_1 && !rise_0) begin
            score_1_d = inc_1;
            point_d   = 1'b1;
            if (win_rule(inc_1, score_0_q)) begin
              state_d  = ST_OVER;
              winner_d = 1'b1;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_OVER: ;
        default: state_d = ST_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= 26'd0;
      score_0_q  <= 4'd0;
      score_1_q  <= 4'd0;
      point_q    <= 1'b0;
      winner_q   <= 1'b0;
      // Preloading with 1 keeps a flag that is already high from counting as a rise.
      prev_0_q   <= 1'b1;
      prev_1_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      score_0_q  <= score_0_d;
      score_1_q  <= score_1_d;
      point_q    <= point_d;
      winner_q   <= winner_d;
      prev_0_q   <= prev_0_d;
      prev_1_q   <= prev_1_d;
    end
  end

  assign score_0   = score_0_q;
  assign score_1   = score_1_q;
  assign point     = point_q;
  assign winner    = winner_q;
  assign go_ball   = (state_q == ST_PLAY);
  assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_score_keeper.sv
// Randomized scoreboard bench for score_keeper against a point-level behavioural model.
module tb_score_keeper;

  localparam int WIN  = 3;
  localparam int HOLD = 10;
  localparam int M_HOLD = 0;
  localparam int M_PLAY = 1;
  localparam int M_OVER = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       new_game = 1'b0;
  logic       p0 = 1'b0;
  logic       p1 = 1'b0;
  logic [3:0] score_0, score_1;
  logic       go_ball, point, game_over, winner;

  score_keeper #(.WIN_SCORE(WIN), .HOLD_CYCLES(26'(HOLD))) dut (
    .clk(clk), .reset(reset), .new_game(new_game),
    .player_0_scores(p0), .player_1_scores(p1),
    .score_0(score_0), .score_1(score_1), .go_ball(go_ball),
    .point(point), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s0;
    int s1;
    int over;
    int win;
  } pt_t;

  pt_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  // Model state: phase, serve cycles remaining, scores, latched winner, last seen flags.
  int m_phase, m_left, m_s0, m_s1, m_win, m_p0, m_p1;
  int m_point;
  bit model_valid = 1'b0;

  function automatic int wins(input int mine, input int other);
`ifdef SCORE_KEEPER_DEUCE_EN
    return ((mine >= WIN) && (mine - other >= 2)) || (mine == 15);
`else
    return (mine >= WIN) ? 1 : 0;
`endif
  endfunction

  task automatic model_update(input int i0, input int i1, input int ng, input int rst);
    int r0, r1;
    pt_t e;
    m_point = 0;
    if (rst != 0) begin
      m_phase = M_HOLD; m_left = HOLD; m_s0 = 0; m_s1 = 0; m_win = 0;
      m_p0 = 1; m_p1 = 1;
      return;
    end
    r0 = (i0 == 1 && m_p0 == 0) ? 1 : 0;
    r1 = (i1 == 1 && m_p1 == 0) ? 1 : 0;
    if (ng != 0) begin
      m_phase = M_HOLD; m_left = HOLD; m_s0 = 0; m_s1 = 0; m_win = 0;
    end else if (m_phase == M_HOLD) begin
      m_left = m_left - 1;
      if (m_left == 0) m_phase = M_PLAY;
    end else if (m_phase == M_PLAY && r0 != r1) begin
      m_point = 1;
      if (r0 == 1) begin
        m_s0 = (m_s0 + 1 > 15) ? 15 : m_s0 + 1;
        if (wins(m_s0, m_s1) != 0) begin m_phase = M_OVER; m_win = 0; end
      end else begin
        m_s1 = (m_s1 + 1 > 15) ? 15 : m_s1 + 1;
        if (wins(m_s1, m_s0) != 0) begin m_phase = M_OVER; m_win = 1; end
      end
      if (m_phase != M_OVER) begin m_phase = M_HOLD; m_left = HOLD; end
      e.s0 = m_s0; e.s1 = m_s1; e.over = (m_phase == M_OVER); e.win = m_win;
      exp_q.push_back(e);
    end
    m_p0 = i0;
    m_p1 = i1;
  endtask

  task automatic step(input logic i0, input logic i1, input logic ng, input logic rst);
    p0 = i0; p1 = i1; new_game = ng; reset = rst;
    @(posedge clk);
    model_update(int'(i0), int'(i1), int'(ng), int'(rst));
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      pt_t e;
      chk("go_ball", int'(go_ball), int'(m_phase == M_PLAY));
      chk("game_over", int'(game_over), int'(m_phase == M_OVER));
      chk("point", int'(point), m_point);
      chk("score_0", int'(score_0), m_s0);
      chk("score_1", int'(score_1), m_s1);
      if (game_over) chk("winner", int'(winner), m_win);
      if (point) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_point", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_score_0", int'(score_0), e.s0);
          chk("sb_score_1", int'(score_1), e.s1);
          chk("sb_game_over", int'(game_over), e.over);
          if (e.over != 0) chk("sb_winner", int'(winner), e.win);
        end
      end
    end
  end

  task automatic wait_play(input int budget);
    int n = 0;
    while (m_phase != M_PLAY && n < budget) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("wait_play_timeout", int'(m_phase == M_PLAY), 1);
  endtask

  task automatic wait_over(input int budget);
    int n = 0;
    while (m_phase != M_OVER && n < budget) begin
      step(n[1], 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("wait_over_timeout", int'(m_phase == M_OVER), 1);
  endtask

  initial begin
    logic c0, c1, ng, rst;
    // Reset with player 0's flag already high: it must never be counted.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    model_valid = 1'b1;
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (25) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Single point with the flag held high for several cycles.
    wait_play(40);
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Simultaneous rise credits nobody and play continues.
    wait_play(40);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Match win, ignored rises in OVER, then new_game racing a rise.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    wait_over(400);
    repeat (6) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-match with a flag high.
    wait_play(40);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0);

    c0 = 1'b0;
    c1 = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 5) == 0) c0 = ~c0;
      if ($urandom_range(0, 5) == 0) c1 = ~c1;
      ng  = ($urandom_range(0, 149) == 0);
      rst = ($urandom_range(0, 799) == 0);
      step(c0, c1, ng, rst);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sb_pending_points", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
